// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the pipeline sequencer.
// The PIPELINE_CTRL_PERF_EN macro is consumed by pipeline_ctrl and does not affect this package.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    LUSTALL,
    DRAIN,
    HALTED
  } pipectrl_state_t;

  localparam int unsigned LU_STALL_MAX = 3;
  localparam int unsigned LU_CNT_W     = 2;
  localparam int unsigned REG_ADDR_W   = 5;

  // Per-cycle control word driven onto the pipeline register bars and the PC.
  typedef struct packed {
    logic pc_en;
    logic pc_sel;
    logic en_1;
    logic en_2;
    logic en_3;
    logic en_4;
    logic flush_1;
    logic flush_2;
    logic flush_3;
  } pipectrl_out_t;

  localparam pipectrl_out_t CTRL_IDLE     = 9'b00_0000_000;
  localparam pipectrl_out_t CTRL_RUN      = 9'b10_1111_000;
  // Front end frozen, bubble into ID/EX, back end keeps draining.
  localparam pipectrl_out_t CTRL_STALL    = 9'b00_0011_010;
  localparam pipectrl_out_t CTRL_REDIRECT = 9'b11_0001_111;
  localparam pipectrl_out_t CTRL_DRAIN    = 9'b00_0001_111;
  localparam pipectrl_out_t CTRL_HALTED   = 9'b00_0000_111;

endpackage

// File: rtl/pipeline_hazard_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
module pipeline_hazard_detect
  import cpu_types_pkg::*;
(
  input  logic                  dREN_ex,
  input  logic [REG_ADDR_W-1:0] rt_ex,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  output logic                  lu_hazard
);

  logic w_dst_valid;
  logic w_src_match;

  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign w_dst_valid = (rt_ex != '0);
  assign w_src_match = (rt_ex == rs_id) || (rt_ex == rt_id);
  assign lu_hazard   = dREN_ex && w_dst_valid && w_src_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Per-stage enable/flush sequencer for the four pipeline bars and the PC.
// Define PIPELINE_CTRL_PERF_EN to add the stall/flush/cycle performance counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  ihit,
  input  logic                  dhit,
  input  logic                  dREN_mem,
  input  logic                  dWEN_mem,
  input  logic                  dREN_ex,
  input  logic [REG_ADDR_W-1:0] rt_ex,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  redirect_mem,
  input  logic                  halt_mem,
  output logic                  pc_en,
  output logic                  pc_sel,
  output logic                  en_1,
  output logic                  en_2,
  output logic                  en_3,
  output logic                  en_4,
  output logic                  flush_1,
  output logic                  flush_2,
  output logic                  flush_3,
`ifdef PIPELINE_CTRL_PERF_EN
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      cycle_cnt,
`endif
  output logic                  halted
);

  if (LU_STALL_CYCLES < 1 || LU_STALL_CYCLES > LU_STALL_MAX || CNT_W < 1) begin : g_bad_param
    $error("pipeline_ctrl: LU_STALL_CYCLES must be 1..3 and CNT_W at least 1");
  end

  localparam logic [LU_CNT_W-1:0] LU_LOAD = LU_CNT_W'(LU_STALL_CYCLES - 1);

  pipectrl_state_t     r_state;
  pipectrl_state_t     w_state_nxt;
  logic [LU_CNT_W-1:0] r_cnt;
  logic [LU_CNT_W-1:0] w_cnt_nxt;
  pipectrl_out_t       w_out;
  logic                w_mem_wait;
  logic                w_lu_hazard;

  assign w_mem_wait = (dREN_mem || dWEN_mem) && !dhit;

  pipeline_hazard_detect u_hazard (
    .dREN_ex   (dREN_ex),
    .rt_ex     (rt_ex),
    .rs_id     (rs_id),
    .rt_id     (rt_id),
    .lu_hazard (w_lu_hazard)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= BOOT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_out       = CTRL_IDLE;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN, LUSTALL: begin
        // A data-side wait freezes every bar and the counter, holding any redirect/halt in MEM.
        if (!w_mem_wait) begin
          if (halt_mem) begin
            w_out       = CTRL_DRAIN;
            w_state_nxt = DRAIN;
            w_cnt_nxt   = '0;
          end else if (redirect_mem) begin
            // Any pending load-use hazard is squashed along with the flushed instructions.
            w_out       = CTRL_REDIRECT;
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else if (r_state == LUSTALL) begin
            w_out = CTRL_STALL;
            if (r_cnt <= LU_CNT_W'(1)) begin
              w_state_nxt = RUN;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt - LU_CNT_W'(1);
            end
          end else if (w_lu_hazard) begin
            w_out       = CTRL_STALL;
            w_cnt_nxt   = LU_LOAD;
            w_state_nxt = (LU_LOAD != '0) ? LUSTALL : RUN;
          end else if (!ihit) begin
            w_out = CTRL_STALL;
          end else begin
            w_out = CTRL_RUN;
          end
        end
      end
      DRAIN: begin
        w_out       = CTRL_DRAIN;
        w_state_nxt = HALTED;
      end
      HALTED: begin
        w_out = CTRL_HALTED;
      end
      default: begin
        w_state_nxt = BOOT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign pc_en   = w_out.pc_en;
  assign pc_sel  = w_out.pc_sel;
  assign en_1    = w_out.en_1;
  assign en_2    = w_out.en_2;
  assign en_3    = w_out.en_3;
  assign en_4    = w_out.en_4;
  assign flush_1 = w_out.flush_1;
  assign flush_2 = w_out.flush_2;
  assign flush_3 = w_out.flush_3;
  assign halted  = (r_state == HALTED);

`ifdef PIPELINE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic             w_in_run;
  logic             w_active;

  assign w_in_run = (r_state == RUN) || (r_state == LUSTALL);
  assign w_active = w_in_run || (r_state == DRAIN);

  // pc_sel is asserted only on an accepted redirect, so it doubles as the redirect event.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_cycle_cnt <= '0;
    end else begin
      if (w_in_run && !pc_en && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (pc_sel && !(&r_flush_cnt))             r_flush_cnt <= r_flush_cnt + CNT_ONE;
      if (w_active && !(&r_cycle_cnt))           r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench: two sequencers (1 and 3 load-use bubbles) against a behavioural model.
module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       ihit = 1'b0, dhit = 1'b0, dREN_mem = 1'b0, dWEN_mem = 1'b0, dREN_ex = 1'b0;
  logic [4:0] rt_ex = '0, rs_id = '0, rt_id = '0;
  logic       redirect_mem = 1'b0, halt_mem = 1'b0;

  // Output word order: pc_en pc_sel en_1 en_2 en_3 en_4 flush_1 flush_2 flush_3 halted
  wire [9:0] o1, o3;

  localparam logic [9:0] X_ZERO  = 10'b00_0000_000_0;
  localparam logic [9:0] X_RUN   = 10'b10_1111_000_0;
  localparam logic [9:0] X_STALL = 10'b00_0011_010_0;
  localparam logic [9:0] X_REDIR = 10'b11_0001_111_0;
  localparam logic [9:0] X_DRAIN = 10'b00_0001_111_0;
  localparam logic [9:0] X_HALT  = 10'b00_0000_111_1;

  int checks = 0;
  int errors = 0;

`ifdef PIPELINE_CTRL_PERF_EN
  wire [31:0] s1, f1, c1, s3, f3, c3;
`endif

  pipeline_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(32)) dut1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_mem(dREN_mem),
    .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .redirect_mem(redirect_mem), .halt_mem(halt_mem),
    .pc_en(o1[9]), .pc_sel(o1[8]), .en_1(o1[7]), .en_2(o1[6]), .en_3(o1[5]), .en_4(o1[4]),
    .flush_1(o1[3]), .flush_2(o1[2]), .flush_3(o1[1]),
`ifdef PIPELINE_CTRL_PERF_EN
    .stall_cnt(s1), .flush_cnt(f1), .cycle_cnt(c1),
`endif
    .halted(o1[0])
  );

  pipeline_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(32)) dut3 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_mem(dREN_mem),
    .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .redirect_mem(redirect_mem), .halt_mem(halt_mem),
    .pc_en(o3[9]), .pc_sel(o3[8]), .en_1(o3[7]), .en_2(o3[6]), .en_3(o3[5]), .en_4(o3[4]),
    .flush_1(o3[3]), .flush_2(o3[2]), .flush_3(o3[1]),
`ifdef PIPELINE_CTRL_PERF_EN
    .stall_cnt(s3), .flush_cnt(f3), .cycle_cnt(c3),
`endif
    .halted(o3[0])
  );

  always #5 CLK = ~CLK;

  // Model: phase flags plus the number of bubbles still owed after the current one.
  typedef struct {
    bit boot;
    bit drain;
    bit halted;
    int owed;
  } mdl_t;

  mdl_t m1, m3;

  function automatic bit mem_wait();
    return (dREN_mem || dWEN_mem) && !dhit;
  endfunction

  function automatic bit hazard();
    return dREN_ex && (rt_ex != 0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
  endfunction

  function automatic logic [9:0] mexp(mdl_t m);
    if (m.boot)           return X_ZERO;
    if (m.halted)         return X_HALT;
    if (m.drain)          return X_DRAIN;
    if (mem_wait())       return X_ZERO;
    if (halt_mem)         return X_DRAIN;
    if (redirect_mem)     return X_REDIR;
    if (m.owed > 0)       return X_STALL;
    if (hazard() || !ihit) return X_STALL;
    return X_RUN;
  endfunction

  function automatic mdl_t mnext(mdl_t m, int bubbles);
    mdl_t n = m;
    if (!nRST) begin
      n.boot = 1; n.drain = 0; n.halted = 0; n.owed = 0;
    end else if (m.boot) begin
      n.boot = 0;
    end else if (m.halted) begin
      n.halted = 1;
    end else if (m.drain) begin
      n.drain = 0; n.halted = 1;
    end else if (mem_wait()) begin
      n = m;
    end else if (halt_mem) begin
      n.drain = 1; n.owed = 0;
    end else if (redirect_mem) begin
      n.owed = 0;
    end else if (m.owed > 0) begin
      n.owed = m.owed - 1;
    end else if (hazard()) begin
      n.owed = bubbles - 1;
    end
    return n;
  endfunction

  task automatic cycle();
    mdl_t n1, n3;
    n1 = mnext(m1, 1);
    n3 = mnext(m3, 3);
    @(posedge CLK);
    m1 = n1;
    m3 = n3;
    #1;
  endtask

  task automatic set_idle();
    ihit = 1; dhit = 0; dREN_mem = 0; dWEN_mem = 0; dREN_ex = 0;
    rt_ex = 0; rs_id = 0; rt_id = 0; redirect_mem = 0; halt_mem = 0;
  endtask

  task automatic set_random();
    ihit         = ($urandom_range(0, 9) < 8);
    dhit         = $urandom_range(0, 1);
    dREN_mem     = ($urandom_range(0, 9) < 2);
    dWEN_mem     = ($urandom_range(0, 9) < 1);
    dREN_ex      = $urandom_range(0, 1);
    rt_ex        = 5'($urandom_range(0, 3));
    rs_id        = 5'($urandom_range(0, 3));
    rt_id        = 5'($urandom_range(0, 3));
    redirect_mem = ($urandom_range(0, 7) == 0);
    halt_mem     = ($urandom_range(0, 39) == 0);
  endtask

  task automatic test_reset();
    nRST = 0;
    set_idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      #1;
      checks++;
      if (o1 !== X_ZERO || o3 !== X_ZERO) begin
        errors++;
        $display("FAIL reset_hold cyc%0d got %b/%b want %b", i, o1, o3, X_ZERO);
      end
    end
    nRST = 1;
    #1;
    checks++;
    if (o1 !== X_ZERO || o3 !== X_ZERO) begin
      errors++;
      $display("FAIL boot_cycle got %b/%b want %b", o1, o3, X_ZERO);
    end
    cycle();
    #1;
    checks++;
    if (o1 !== X_RUN || o3 !== X_RUN || mexp(m1) !== X_RUN) begin
      errors++;
      $display("FAIL first_run got %b/%b want %b", o1, o3, X_RUN);
    end
  endtask

  task automatic test_load_use();
    int n1, n3;
    n1 = 0; n3 = 0;
    set_idle();
    dREN_ex = 1; rt_ex = 8; rs_id = 8;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (o1 !== mexp(m1) || o3 !== mexp(m3)) begin
        errors++;
        $display("FAIL lu_step%0d got %b/%b want %b/%b", i, o1, o3, mexp(m1), mexp(m3));
      end
      if (o1 === X_STALL) n1++;
      if (o3 === X_STALL) n3++;
      cycle();
      set_idle();
    end
    checks++;
    if (n1 != 1) begin
      errors++;
      $display("FAIL lu_bubbles_1 got %0d want 1", n1);
    end
    checks++;
    if (n3 != 3) begin
      errors++;
      $display("FAIL lu_bubbles_3 got %0d want 3", n3);
    end
    dREN_ex = 1; rt_ex = 0; rs_id = 0; rt_id = 0;
    #1;
    checks++;
    if (o1 !== X_RUN || o3 !== X_RUN) begin
      errors++;
      $display("FAIL lu_r0 got %b/%b want %b", o1, o3, X_RUN);
    end
    cycle();
    set_idle();
  endtask

  task automatic test_mem_wait();
    for (int r = 0; r < 2; r++) begin
      set_idle();
      dREN_mem = 1; dhit = 0; redirect_mem = (r == 1);
      for (int i = 0; i < 4; i++) begin
        #1;
        checks++;
        if (o1 !== X_ZERO || o3 !== X_ZERO) begin
          errors++;
          $display("FAIL memwait r%0d cyc%0d got %b/%b want %b", r, i, o1, o3, X_ZERO);
        end
        cycle();
      end
      dhit = 1;
      #1;
      checks++;
      if (o1 !== (r == 1 ? X_REDIR : X_RUN) || o3 !== mexp(m3)) begin
        errors++;
        $display("FAIL memwait_release r%0d got %b/%b want %b", r, o1, o3, mexp(m1));
      end
      cycle();
      set_idle();
      #1;
      checks++;
      if (o1 !== X_RUN || o3 !== X_RUN) begin
        errors++;
        $display("FAIL memwait_after r%0d got %b/%b want %b", r, o1, o3, X_RUN);
      end
    end
  endtask

  task automatic test_redirect_lu();
    set_idle();
    redirect_mem = 1; dREN_ex = 1; rt_ex = 5; rt_id = 5;
    #1;
    checks++;
    if (o1 !== X_REDIR || o3 !== X_REDIR) begin
      errors++;
      $display("FAIL redir_lu got %b/%b want %b", o1, o3, X_REDIR);
    end
    cycle();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o1 !== X_RUN || o3 !== X_RUN) begin
        errors++;
        $display("FAIL redir_after cyc%0d got %b/%b want %b", i, o1, o3, X_RUN);
      end
      cycle();
    end
  endtask

  task automatic test_halt();
    set_idle();
    halt_mem = 1;
    #1;
    checks++;
    if (o1 !== X_DRAIN || o3 !== X_DRAIN) begin
      errors++;
      $display("FAIL halt_accept got %b/%b want %b", o1, o3, X_DRAIN);
    end
    cycle();
    set_idle();
    #1;
    checks++;
    if (o1 !== X_DRAIN || o3 !== X_DRAIN) begin
      errors++;
      $display("FAIL drain got %b/%b want %b", o1, o3, X_DRAIN);
    end
    cycle();
    for (int i = 0; i < 10; i++) begin
      set_random();
      #1;
      checks++;
      if (o1 !== X_HALT || o3 !== X_HALT || o1 !== mexp(m1)) begin
        errors++;
        $display("FAIL halted cyc%0d got %b/%b want %b", i, o1, o3, X_HALT);
      end
      cycle();
    end
    set_idle();
  endtask

  task automatic test_reset_mid_stall();
    nRST = 0;
    set_idle();
    cycle();
    nRST = 1;
    cycle();
    dREN_ex = 1; rt_ex = 9; rs_id = 9;
    cycle();
    set_idle();
    nRST = 0;
    #1;
    checks++;
    if (o3 !== X_STALL || o1 !== X_RUN) begin
      errors++;
      $display("FAIL lustall_pre_reset got %b/%b want %b/%b", o1, o3, X_RUN, X_STALL);
    end
    cycle();
    nRST = 1;
    #1;
    checks++;
    if (o1 !== X_ZERO || o3 !== X_ZERO) begin
      errors++;
      $display("FAIL reset_mid_stall_boot got %b/%b want %b", o1, o3, X_ZERO);
    end
    cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o3 !== X_RUN || o1 !== X_RUN) begin
        errors++;
        $display("FAIL reset_mid_stall_run cyc%0d got %b/%b want %b", i, o1, o3, X_RUN);
      end
      cycle();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      set_random();
      nRST = ($urandom_range(0, 49) != 0);
      #1;
      checks++;
      if (o1 !== mexp(m1) || o3 !== mexp(m3)) begin
        errors++;
        $display("FAIL rand cyc%0d got %b/%b want %b/%b", i, o1, o3, mexp(m1), mexp(m3));
      end
      cycle();
    end
    nRST = 1;
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_redirect_lu();
    test_halt();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Sequencer for the four pipeline register bars (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-bar enable and flush, PC enable and PC-select for every cycle.
- Resolves four stall and flush sources by fixed priority: cache waits, load-use hazards, taken branches/jumps and halt drain.
- Sits between the datapath's hazard inputs and the pipeline register interface's `dhit`/`flush` controls, replacing the single global enable and flush with per-stage control.

Parameters:
- LU_STALL_CYCLES, 1, bubble cycles inserted on a load-use hazard (1..3; 1 assumes MEM/WB forwarding).
- CNT_W, 32, width of performance counters (see Optional Feature).

Ports:
- CLK  in  1  system clock.
- nRST  in  1  synchronous active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- dREN_mem  in  1  EX/MEM bar output: load in MEM.
- dWEN_mem  in  1  EX/MEM bar output: store in MEM.
- dREN_ex  in  1  ID/EX bar output: load in EX.
- rt_ex  in  5  ID/EX bar output: destination of load in EX.
- rs_id  in  5  rs field of IF/ID instruction.
- rt_id  in  5  rt field of IF/ID instruction.
- redirect_mem  in  1  taken beq/bne or j/jal/JR resolved in MEM.
- halt_mem  in  1  halt in MEM.
- pc_en  out  1  PC update enable.
- pc_sel  out  1  1 = load redirect target, 0 = PC+4.
- en_1  out  1  enable for IF/ID.
- en_2  out  1  enable for ID/EX.
- en_3  out  1  enable for EX/MEM.
- en_4  out  1  enable for MEM/WB.
- flush_1  out  1  flush for IF/ID (writes a bubble).
- flush_2  out  1  flush for ID/EX.
- flush_3  out  1  flush for EX/MEM.
- halted  out  1  sticky: pipeline drained after halt.

Behaviour:
- Outputs are combinational from the registered state, the registered stall counter and the current inputs.
- All state updates occur on the CLK rising edge.
- nRST=0 at an edge forces: state=BOOT, counter=0, halted=0.
- States:
  - BOOT: all outputs 0 for exactly one cycle, then RUN.
  - RUN: normal operation; priority rules below, first match wins.
  - LUSTALL: load-use bubble insertion.
  - DRAIN: halt has been seen in MEM.
  - HALTED: terminal until reset.
- RUN priority 1, mem wait — (dREN_mem|dWEN_mem)&!dhit:
  - pc_en=0, en_1..en_4=0, no flush.
  - A pending redirect or halt in MEM is held, not lost.
- RUN priority 2, halt — halt_mem and MEM not waiting:
  - flush_1..flush_3=1, en_4=1, pc_en=0.
  - Go to DRAIN.
- RUN priority 3, redirect — redirect_mem:
  - pc_en=1, pc_sel=1, flush_1..flush_3=1, en_4=1.
  - Suppresses any same-cycle load-use stall; the hazard is discarded with the flushed instructions.
- RUN priority 4, load-use — dREN_ex & rt_ex!=0 & (rt_ex==rs_id | rt_ex==rt_id):
  - pc_en=0, en_1=0, flush_2=1, en_3=en_4=1.
  - counter loads LU_STALL_CYCLES-1; if non-zero go to LUSTALL, else stay in RUN.
- RUN priority 5, fetch wait — !ihit:
  - pc_en=0, en_1=0, flush_2=1, later bars advance.
  - Prevents duplicated instructions in ID/EX.
- RUN otherwise: all enables 1, pc_sel=0, no flush.
- LUSTALL:
  - Outputs as in the load-use case.
  - counter decrements each non-mem-wait cycle.
  - When counter==0 at the edge, return to RUN.
  - Mem wait freezes everything including the counter.
  - A redirect in LUSTALL behaves as in RUN and returns to RUN.
- DRAIN:
  - pc_en=0, en_4=1, flush_1..flush_3=1.
  - After one cycle (halt retired through WB) go to HALTED.
- HALTED:
  - halted=1, all enables 0, flush_1..flush_3=1.
  - Stays here regardless of inputs until nRST=0.
- Simultaneous events: mem wait > halt > redirect > load-use > fetch wait.
- Reset mid-stall or mid-drain: state returns to BOOT, counter is cleared, halted clears.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- When defined, add outputs stall_cnt[CNT_W], flush_cnt[CNT_W] and cycle_cnt[CNT_W].
  - stall_cnt counts cycles with pc_en=0 in RUN/LUSTALL.
  - flush_cnt counts redirect events.
  - cycle_cnt counts non-BOOT, non-HALTED cycles.
- Counters clear on reset, saturate at all-ones and freeze in HALTED.
- When not defined, these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- pipectrl_state_t (BOOT, RUN, LUSTALL, DRAIN, HALTED) and LU_STALL_MAX=3 go in cpu_types_pkg.
- One natural sub-module, pipeline_hazard_detect: combinational load-use compare, with inputs dREN_ex, rt_ex, rs_id, rt_id and output lu_hazard.

Test Plan:
- Reset held 3 cycles then released:
  - all outputs 0 during reset and for the BOOT cycle;
  - next cycle ihit=1 gives pc_en=en_1..en_4=1.
- Load-use hazard: dREN_ex=1, rt_ex=8, rs_id=8 with LU_STALL_CYCLES=1:
  - exactly one cycle of pc_en=0, en_1=0, flush_2=1, then normal flow.
  - Repeat with LU_STALL_CYCLES=3 to get 3 cycles; repeat with rt_ex=0 to get no stall.
- dREN_mem=1, dhit=0 for 4 cycles, then dhit=1:
  - en_1..en_4=0 and pc_en=0 for 4 cycles, then a single advance;
  - a redirect_mem held during the wait flushes only on the dhit cycle.
- redirect_mem=1 coincident with a load-use hazard:
  - pc_sel=1, flush_1..flush_3=1, no load-use stall cycle.
- halt_mem=1:
  - DRAIN for 1 cycle, then halted=1 permanently;
  - pc_en remains 0 for 10 further cycles of random inputs.
- nRST=0 asserted during LUSTALL (counter=2):
  - next cycle state=BOOT, counter=0, halted=0, then normal RUN.
